mem_stage: RTL

Memory-access stage of the five-stage RV32 pipeline: consumes the EX/MEM register outputs produced by the execute stage, runs loads/stores on the data-memory bus with a req/ready handshake, and drives the MEM/WB pipeline register. It generates `mem_stall`, which freezes EX/MEM and all upstream stages while a data access is outstanding. It also forwards branch and jump redirects to fetch.

---
 rtl/mem_stage.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : RV32 memory-access stage, data-bus handshake with timeout abort
// Rev 1.0
// ============================================================================
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ex_mem_reg_write,
  input  logic        ex_mem_mem_read,
  input  logic        ex_mem_mem_write,
  input  logic        ex_mem_jump,
  input  logic        ex_mem_branch_taken,
  input  logic [1:0]  ex_mem_mem_to_reg,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_rdata2,
  input  logic [31:0] ex_mem_pc_plus4,
  input  logic [31:0] ex_mem_branch_target,
  input  logic [31:0] ex_mem_jump_target,
  input  logic [4:0]  ex_mem_rd,

  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,

  output logic        mem_stall,
  output logic        pc_redirect,
  output logic [31:0] pc_redirect_target,

  output logic        mem_wb_reg_write,
  output logic [1:0]  mem_wb_mem_to_reg,
  output logic [31:0] mem_wb_alu_result,
  output logic [31:0] mem_wb_mem_rdata,
  output logic [31:0] mem_wb_pc_plus4,
  output logic [4:0]  mem_wb_rd,
  output logic        mem_wb_fault
);

  localparam int                 CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              w_op;
  logic              w_misaligned;
  logic              w_req;
  logic              w_timeout_fire;
  logic              w_stall;
  logic              w_fault;
  logic              w_load_done;

  logic              reg_write_q, reg_write_d;
  logic [1:0]        mem_to_reg_q, mem_to_reg_d;
  logic [31:0]       alu_result_q, alu_result_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic [31:0]       pc_plus4_q, pc_plus4_d;
  logic [4:0]        rd_q, rd_d;
  logic              fault_q, fault_d;

  assign w_op         = ex_mem_mem_read | ex_mem_mem_write;
  assign w_misaligned = (ex_mem_alu_result[1:0] != 2'b00);
  assign w_req        = w_op & ~w_misaligned;

  assign dmem_req   = w_req;
  assign dmem_we    = ex_mem_mem_write;
  assign dmem_addr  = ex_mem_alu_result;
  assign dmem_wdata = ex_mem_rdata2;

  // Ready in the final counted cycle still wins over the abort.
  assign w_timeout_fire = (state_q == S_WAIT) & w_req & ~dmem_ready & (cnt_q == CNT_LAST);
  assign w_stall        = w_req & ~dmem_ready & ~w_timeout_fire;
  assign w_fault        = (w_op & w_misaligned) | w_timeout_fire;
  assign w_load_done    = w_req & dmem_ready & ex_mem_mem_read & ~ex_mem_mem_write;

  assign mem_stall          = w_stall;
  assign pc_redirect        = (ex_mem_jump | ex_mem_branch_taken) & ~w_stall;
  assign pc_redirect_target = ex_mem_jump ? ex_mem_jump_target : ex_mem_branch_target;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_req & ~dmem_ready) begin
          state_d = S_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      S_WAIT: begin
        if (~w_req | dmem_ready | (cnt_q == CNT_LAST)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A stalled cycle inserts a bubble; payload fields hold their last value.
  always_comb begin
    reg_write_d  = 1'b0;
    fault_d      = 1'b0;
    mem_to_reg_d = mem_to_reg_q;
    alu_result_d = alu_result_q;
    mem_rdata_d  = mem_rdata_q;
    pc_plus4_d   = pc_plus4_q;
    rd_d         = rd_q;
    if (!w_stall) begin
      reg_write_d  = ex_mem_reg_write & ~w_fault;
      fault_d      = w_fault;
      mem_to_reg_d = ex_mem_mem_to_reg;
      alu_result_d = ex_mem_alu_result;
      pc_plus4_d   = ex_mem_pc_plus4;
      rd_d         = ex_mem_rd;
      if (w_load_done) begin
        mem_rdata_d = dmem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 2'b00;
      alu_result_q <= '0;
      mem_rdata_q  <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
      fault_q      <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_result_q <= alu_result_d;
      mem_rdata_q  <= mem_rdata_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
      fault_q      <= fault_d;
    end
  end

  assign mem_wb_reg_write  = reg_write_q;
  assign mem_wb_mem_to_reg = mem_to_reg_q;
  assign mem_wb_alu_result = alu_result_q;
  assign mem_wb_mem_rdata  = mem_rdata_q;
  assign mem_wb_pc_plus4   = pc_plus4_q;
  assign mem_wb_rd         = rd_q;
  assign mem_wb_fault      = fault_q;

endmodule
`default_nettype wire
